code_sequencer: RTL

Program sequencer that sits directly upstream of the training controller. It holds a small opcode program and drives the controller's op, code_count, code_index and enable. It consumes the controller's feedback strobes (count reset, code-line advance, code-line reset) to step through the program and count epochs. It raises done when the requested number of epochs has completed.

---
 rtl/nb_pkg.sv | 16 +
 rtl/code_mem.sv | 23 ++
 rtl/code_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/nb_pkg.sv
// Shared definitions for the training datapath: opcodes, sequencer states and code widths.
package nb_pkg;

  localparam int CODE_W = 32;

  localparam int OP_NOP       = 0;
  localparam int OP_SET_LAYER = 1;
  localparam int OP_SET_COST  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/code_mem.sv
// Opcode program store: one synchronous write port, one combinational read port.
module code_mem #(
  parameter  int OP_SIZE    = 4,
  parameter  int CODE_DEPTH = 16,
  localparam int AW         = $clog2(CODE_DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [OP_SIZE-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [OP_SIZE-1:0] rdata
);

  logic [OP_SIZE-1:0] mem [CODE_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/code_sequencer.sv
// Steps an opcode program on the controller's feedback strobes, counts epochs,
// and pulses done for one cycle when the last epoch ends.
module code_sequencer
  import nb_pkg::*;
#(
  parameter  int OP_SIZE    = 4,
  parameter  int CODE_DEPTH = 16,
  localparam int AW         = $clog2(CODE_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [OP_SIZE-1:0] prog_data,
  input  logic [AW:0]        prog_len,
  input  logic [31:0]        epochs,
  input  logic               start,
  input  logic               stop,
  input  logic               cnt_reset,
  input  logic               code_active,
  input  logic               code_reset,
  output logic [OP_SIZE-1:0] op,
  output logic [31:0]        code_count,
  output logic [31:0]        code_index,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic [31:0]        epoch_left
);

  seq_state_t          state, state_n;
  logic [AW-1:0]       idx_r, idx_n;
  logic [CODE_W-1:0]   cnt_r, cnt_n;
  logic [31:0]         ep_r, ep_n;
  logic [AW:0]         len_r, len_n;
  logic [OP_SIZE-1:0]  mem_op;
  logic                last_line;
  logic                end_epoch;

  code_mem #(
    .OP_SIZE    (OP_SIZE),
    .CODE_DEPTH (CODE_DEPTH)
  ) u_code_mem (
    .clk   (clk),
    .we    (prog_we && (state == IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (idx_r),
    .rdata (mem_op)
  );

  // A count reset with advance on the last line is an epoch end, same as code_reset.
  assign last_line = ({1'b0, idx_r} == (len_r - 1'b1));
  assign end_epoch = code_reset || (cnt_reset && code_active && last_line);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    idx_n   = idx_r;
    cnt_n   = cnt_r;
    ep_n    = ep_r;
    len_n   = len_r;
    case (state)
      IDLE: begin
        if (start) begin
          if ((epochs == '0) || (prog_len == '0)) begin
            state_n = FIN;
            ep_n    = '0;
          end else begin
            state_n = RUN;
            idx_n   = '0;
            cnt_n   = '0;
            ep_n    = epochs;
            len_n   = prog_len;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (end_epoch) begin
          idx_n = '0;
          cnt_n = '0;
          ep_n  = ep_r - 32'd1;
          if (ep_r == 32'd1) state_n = FIN;
        end else if (cnt_reset) begin
          cnt_n = '0;
          if (code_active) idx_n = idx_r + 1'b1;
        end else if (cnt_r != '1) begin
          // A lone code_active is a spurious strobe: the line keeps accruing cycles.
          cnt_n = cnt_r + 32'd1;
        end
      end
      FIN: begin
        state_n = IDLE;
        idx_n   = '0;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= '0;
      cnt_r <= '0;
      ep_r  <= '0;
      len_r <= '0;
    end else begin
      idx_r <= idx_n;
      cnt_r <= cnt_n;
      ep_r  <= ep_n;
      len_r <= len_n;
    end
  end

  assign op         = (state == RUN) ? mem_op : '0;
  assign code_count = cnt_r;
  assign code_index = {{(CODE_W-AW){1'b0}}, idx_r};
  assign enable     = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = (state == FIN);
  assign epoch_left = ep_r;

endmodule
